// File: rtl/seg_scan_if.sv
// Bundle of the display controller's load request, display controls and scan outputs.
// load is a single-cycle strobe with no ready: the controller accepts every load it sees.
interface seg_scan_if #(
  parameter int NUM_DIGITS = 4,
  parameter int SEL_W      = $clog2(NUM_DIGITS)
);
  logic                    load;
  logic [NUM_DIGITS*4-1:0] value;
  logic                    blank_lz;
  logic [3:0]              brightness;
  logic [SEL_W-1:0]        digit_sel;
  logic [3:0]              nibble;
  logic                    digit_on;
  logic                    loaded;

  modport master (
    output load, value, blank_lz, brightness,
    input  digit_sel, nibble, digit_on, loaded
  );

  modport slave (
    input  load, value, blank_lz, brightness,
    output digit_sel, nibble, digit_on, loaded
  );
endinterface

// File: rtl/seg_scan_ctrl.sv
// Multiplexed N-digit 7-segment scan controller: frame-synchronous double-buffered
// value, leading-zero blanking and 16-level PWM brightness, all outputs registered.
module seg_scan_ctrl #(
  parameter int NUM_DIGITS = 4,
  parameter int DIV_BITS   = 14,
  parameter int SEL_W      = $clog2(NUM_DIGITS)
) (
  input  logic        clk,
  input  logic        reset,
  seg_scan_if.slave   bus
);
  localparam int              VW       = NUM_DIGITS * 4;
  localparam logic [SEL_W-1:0] LAST_IDX = SEL_W'(NUM_DIGITS - 1);

  logic [DIV_BITS-1:0]   r_div;
  logic [SEL_W-1:0]      r_idx;
  logic [VW-1:0]         r_shd;
  logic [VW-1:0]         r_disp;
  logic                  r_pending;
  logic                  r_commit;
  logic [SEL_W-1:0]      r_digit_sel;
  logic [3:0]            r_nibble;
  logic                  r_digit_on;
  logic                  r_loaded;

  logic                  w_div_last;
  logic                  w_boundary;
  logic [3:0]            w_pwm_slot;
  logic [3:0]            w_nibble;
  logic [NUM_DIGITS-1:0] w_blank;
  logic                  w_nz_above;

  assign w_div_last = &r_div;
  assign w_boundary = w_div_last && (r_idx == LAST_IDX);
  assign w_pwm_slot = r_div[DIV_BITS-1 -: 4];
  assign w_nibble   = r_disp[{r_idx, 2'b00} +: 4];

  // Walk from the most significant digit down; a digit is blanked while every digit
  // at or above it is zero. Digit 0 is never blanked so a zero value shows "0".
  always_comb begin
    w_blank    = '0;
    w_nz_above = 1'b0;
    for (int i = NUM_DIGITS - 1; i >= 0; i--) begin
      w_nz_above = w_nz_above | (|r_disp[4*i +: 4]);
      if (i > 0) w_blank[i] = bus.blank_lz && !w_nz_above;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_div     <= '0;
      r_idx     <= '0;
      r_shd     <= '0;
      r_disp    <= '0;
      r_pending <= 1'b0;
      r_commit  <= 1'b0;
    end else begin
      r_div <= r_div + 1'b1;
      if (w_div_last) r_idx <= (r_idx == LAST_IDX) ? '0 : r_idx + 1'b1;

      // A load landing on the boundary bypasses the shadow and shows immediately.
      r_commit <= w_boundary && (bus.load || r_pending);
      if (w_boundary) begin
        if (bus.load)      r_disp <= bus.value;
        else if (r_pending) r_disp <= r_shd;
        r_pending <= 1'b0;
      end else if (bus.load) begin
        r_shd     <= bus.value;
        r_pending <= 1'b1;
      end
    end
  end

  // loaded is delayed one clock behind the commit so it lines up with digit 0 of
  // the new frame on the registered outputs.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_digit_sel <= '0;
      r_nibble    <= '0;
      r_digit_on  <= 1'b0;
      r_loaded    <= 1'b0;
    end else begin
      r_digit_sel <= r_idx;
      r_nibble    <= w_nibble;
      r_digit_on  <= (w_pwm_slot < bus.brightness) && !w_blank[r_idx];
      r_loaded    <= r_commit;
    end
  end

  assign bus.digit_sel = r_digit_sel;
  assign bus.nibble    = r_nibble;
  assign bus.digit_on  = r_digit_on;
  assign bus.loaded    = r_loaded;
endmodule

// File: tb/tb_seg_scan_ctrl.sv
// Bench for seg_scan_ctrl at NUM_DIGITS=4, DIV_BITS=4 (dwell 16, frame 64).
// Cycle n counts rising edges after reset release; commit edges are multiples of 64.
module tb_seg_scan_ctrl;
  logic clk;
  logic reset;
  int   checks = 0;
  int   errors = 0;
  int   cyc    = 0;
  logic [31:0] exp_q[$];

  seg_scan_if #(.NUM_DIGITS(4)) bus ();

  seg_scan_ctrl #(.NUM_DIGITS(4), .DIV_BITS(4)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [15:0] value;
    logic        blz;
    logic [3:0]  br;
    int          load_edge;
    logic [3:0]  on_mask;
  } vec_t;

  vec_t vecs[8];

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: cycle %0d got %0d expected %0d", name, cyc, act, exp);
    end
  endtask

  // One clock; the loaded scoreboard is checked on every tick.
  task automatic tick();
    logic [31:0] e;
    @(posedge clk);
    #1;
    cyc++;
    if (bus.loaded === 1'b1) begin
      checks++;
      if (exp_q.size() == 0) begin
        errors++;
        $display("FAIL loaded_pulse: unexpected pulse at cycle %0d", cyc);
      end else begin
        e = exp_q.pop_front();
        if (e != 32'(cyc)) begin
          errors++;
          $display("FAIL loaded_pulse: pulse at cycle %0d expected at %0d", cyc, e);
        end
      end
    end else if (exp_q.size() > 0 && exp_q[0] == 32'(cyc)) begin
      checks++;
      errors++;
      $display("FAIL loaded_pulse: no pulse at cycle %0d where one was expected", cyc);
      void'(exp_q.pop_front());
    end
  endtask

  task automatic do_reset();
    exp_q.delete();
    reset = 1'b1;
    for (int k = 0; k < 3; k++) begin
      @(posedge clk);
      #1;
      bus.load = 1'b0;
      check("rst_digit_sel", int'(bus.digit_sel), 0);
      check("rst_nibble",    int'(bus.nibble),    0);
      check("rst_digit_on",  int'(bus.digit_on),  0);
      check("rst_loaded",    int'(bus.loaded),    0);
    end
    reset = 1'b0;
    cyc   = 0;
  endtask

  // Commit happens at the first multiple-of-64 edge at or after the load edge.
  task automatic do_load(input logic [15:0] v);
    logic [31:0] e;
    bus.load  = 1'b1;
    bus.value = v;
    tick();
    e = 32'(((cyc + 63) / 64) * 64 + 1);
    if (exp_q.size() == 0 || exp_q[$] != e) exp_q.push_back(e);
    bus.load = 1'b0;
  endtask

  task automatic run_to(input int n);
    while (cyc < n) tick();
  endtask

  initial begin
    logic [15:0] v;
    int          d;
    int          slot;
    int          exp_on;

    vecs[0] = '{value: 16'hA5C3, blz: 1'b0, br: 4'd15, load_edge: 10, on_mask: 4'b1111};
    vecs[1] = '{value: 16'h0040, blz: 1'b1, br: 4'd15, load_edge: 1,  on_mask: 4'b0011};
    vecs[2] = '{value: 16'h0000, blz: 1'b1, br: 4'd15, load_edge: 40, on_mask: 4'b0001};
    vecs[3] = '{value: 16'h0000, blz: 1'b0, br: 4'd15, load_edge: 63, on_mask: 4'b1111};
    vecs[4] = '{value: 16'h3333, blz: 1'b0, br: 4'd15, load_edge: 64, on_mask: 4'b1111};
    vecs[5] = '{value: 16'h0040, blz: 1'b0, br: 4'd4,  load_edge: 20, on_mask: 4'b1111};
    vecs[6] = '{value: 16'h1234, blz: 1'b1, br: 4'd0,  load_edge: 5,  on_mask: 4'b1111};
    vecs[7] = '{value: 16'h0500, blz: 1'b1, br: 4'd8,  load_edge: 30, on_mask: 4'b0111};

    reset          = 1'b1;
    bus.load       = 1'b0;
    bus.value      = '0;
    bus.blank_lz   = 1'b0;
    bus.brightness = 4'd0;

    // Reset and free scan: digit_sel steps every 16 clocks, nothing lit, no pulse.
    do_reset();
    for (int n = 1; n <= 80; n++) begin
      tick();
      check("scan_digit_sel", int'(bus.digit_sel), ((n - 1) >> 4) & 3);
      check("scan_nibble",    int'(bus.nibble),    0);
      check("scan_digit_on",  int'(bus.digit_on),  0);
    end

    // Table rows: load at a chosen edge, then check the whole committed frame.
    for (int r = 0; r < 8; r++) begin
      do_reset();
      bus.blank_lz   = vecs[r].blz;
      bus.brightness = vecs[r].br;
      run_to(vecs[r].load_edge - 1);
      do_load(vecs[r].value);
      run_to(64);
      v = vecs[r].value;
      for (int n = 65; n <= 128; n++) begin
        tick();
        d      = ((n - 1) >> 4) & 3;
        slot   = (n - 1) & 15;
        exp_on = (vecs[r].on_mask[d] && (slot < int'(vecs[r].br))) ? 1 : 0;
        check("row_digit_sel", int'(bus.digit_sel), d);
        check("row_nibble",    int'(bus.nibble),    int'((v >> (4 * d)) & 16'hF));
        check("row_digit_on",  int'(bus.digit_on),  exp_on);
      end
    end

    // Two loads in one frame: single pulse, later value shown, no pulse next frame.
    do_reset();
    bus.blank_lz   = 1'b0;
    bus.brightness = 4'd15;
    run_to(4);
    do_load(16'h1111);
    run_to(29);
    do_load(16'h2222);
    run_to(64);
    for (int n = 65; n <= 200; n++) begin
      tick();
      check("lastwins_nibble", int'(bus.nibble), 2);
    end

    // Reset with a pending value and a simultaneous load: nothing is ever shown.
    do_reset();
    run_to(19);
    do_load(16'hBEEF);
    run_to(40);
    bus.load  = 1'b1;
    bus.value = 16'hCAFE;
    do_reset();
    for (int n = 1; n <= 128; n++) begin
      tick();
      check("rstpend_nibble", int'(bus.nibble), 0);
    end

    check("sb_queue_empty", exp_q.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/seg_scan_ctrl.md
# seg_scan_ctrl

Parametrised multiplexed 7-segment scan controller for the BoosterPack display. It holds an N-digit hex value and scans one digit at a time, producing a digit index for `decode2` and a nibble for `decode7`. New values are double-buffered and committed only at frame boundaries, so the display never tears. It adds leading-zero blanking and 16-level PWM brightness, and replaces the free-running divider and hard-wired digit mux in the top level.

## Interface
Parameters:
- `NUM_DIGITS`, 4: number of scanned digits, 2..8.
- `DIV_BITS`, 14: digit dwell is 2^DIV_BITS clocks; must be ≥ 4.
- `SEL_W`, $clog2(NUM_DIGITS): width of the digit index.

Ports:
- `clk` input 1: single clock (50 MHz in system).
- `reset` input 1: synchronous, active-high reset.
- `load` input 1: one-cycle request to display `value`.
- `value` input NUM_DIGITS*4: hex value; digit i is `value[4i+3:4i]`, and digit 0 is least significant.
- `blank_lz` input 1: enables leading-zero blanking.
- `brightness` input 4: PWM duty, 0 = dark, 15 = 15/16 on.
- `digit_sel` output SEL_W: index of the digit being driven.
- `nibble` output 4: hex value for the selected digit.
- `digit_on` output 1: digit enable (PWM gated, blanking applied).
- `loaded` output 1: one-cycle pulse when a pending value is committed to the display.

## Operation
- **State:**
  - `div` [DIV_BITS], `idx` [SEL_W].
  - Shadow register `shd` and display register `disp`, each NUM_DIGITS*4.
  - `pending` flag.
- **Divider and index:**
  - `div` increments every clock and wraps to 0.
  - When `div` is all-ones, `idx` advances on that clock: `idx` = NUM_DIGITS-1 wraps to 0.
- **Frame boundary:** the clock where `div` is all-ones and `idx` = NUM_DIGITS-1.
- **Load handling:**
  - `load` outside a boundary: `shd` takes `value` and `pending` is set to 1.
  - `load` while already pending: `shd` is overwritten (last load wins), and no extra `loaded` pulse occurs.
  - At a boundary with `pending`=1 and no `load`: `disp` takes `shd`, `pending` clears, and `loaded` pulses.
  - At a boundary with `load`=1: `disp` takes `value` directly (bypass), `pending` clears, and `loaded` pulses.
  - At a boundary with neither `load` nor `pending`: `disp` is unchanged and there is no pulse.
- **Leading-zero blanking:**
  - Digit i is blanked when `blank_lz`=1, i > 0, and every `disp` digit from NUM_DIGITS-1 down to i is 0.
  - Digit 0 is never blanked, so value 0 shows a single "0".
- **PWM:**
  - `pwm_slot` = `div[DIV_BITS-1 -: 4]`.
  - Digit lit iff `pwm_slot` < `brightness`.
  - `brightness` is sampled live; changes take effect within the current dwell.
- **Blanked digits:**
  - `digit_on`=0 and `nibble` = `disp` digit (not forced).
  - `digit_sel` keeps scanning.
- **Invalid `idx`:** never reached. Non-power-of-two NUM_DIGITS wraps at NUM_DIGITS-1, not at 2^SEL_W-1.

## Timing
- **Reset values:** on the clock with `reset`=1:
  - `div`=0, `idx`=0, `shd`=0, `disp`=0, `pending`=0.
  - Outputs `digit_sel`=0, `nibble`=0, `digit_on`=0, `loaded`=0.
- **Reset mid-operation:** reset overrides a simultaneous `load` and discards any pending value.
- **Registered outputs:** all outputs are registered. `digit_sel`/`nibble`/`digit_on` reflect the `idx`/`div`/`disp` state of the previous clock (1-cycle latency).
- **Dwell and frame:** dwell per digit is 2^DIV_BITS clocks; frame length is NUM_DIGITS*2^DIV_BITS clocks.
- **Load-to-display latency:**
  - `loaded` is high on the clock after the boundary.
  - The new `nibble` appears that same clock with `digit_sel`=0.
  - Worst case `load`→`loaded` is NUM_DIGITS*2^DIV_BITS clocks; best case is 1 clock (load on the boundary).
- **Duty:** `digit_on` high for brightness*2^(DIV_BITS-4) of each 2^DIV_BITS dwell.

## Test plan
Bench parameters: NUM_DIGITS=4, DIV_BITS=4 (dwell 16, frame 64).
1. **Reset and scan:** `reset` for 3 clocks → all outputs 0. `digit_sel` sequence is 0,1,2,3,0 with each value held exactly 16 clocks; `loaded` stays 0.
2. **Load/commit:** `load` with `value`=16'hA5C3 at clock 10 after reset → `loaded` pulses once at clock 65. Next frame `nibble` reads 3,C,5,A for `digit_sel` 0..3.
3. **Last-wins and boundary bypass:**
   - Load 16'h1111 then 16'h2222 within one frame → one `loaded` pulse, and the display shows 2222.
   - Load 16'h3333 exactly on a boundary clock → `loaded` on the next clock with `nibble`=3 at `digit_sel`=0.
4. **Leading-zero blanking:**
   - `value`=16'h0040, `blank_lz`=1, `brightness`=15 → `digit_on` is 0 for digits 3 and 2 and 1 for digits 1 and 0.
   - `value`=0 → only digit 0 lit.
   - `blank_lz`=0 → all four digits lit.
5. **PWM:**
   - `brightness`=0 → `digit_on` never high.
   - `brightness`=4 → high for the first 4 of 16 dwell clocks.
   - `brightness`=15 → high for 15 of 16.
6. **Reset mid-pending:** load 16'hBEEF, then assert `reset` before the boundary → no `loaded` pulse ever, and `nibble` stays 0 over the next two frames.
